// File: rtl/gmii_tx_pkg.sv
// Shared types and constants for the GMII transmit framer.
// Padding to MIN_FRAME is built only when GMII_TX_PAD_EN is defined.
package gmii_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  localparam int          PRE_LEN       = 7;
  localparam logic [10:0] CNT_MAX       = 11'd2047;

  // Bit reversal, used to derive the LSB-first form of CRC_POLY.
  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// One-byte update of the Ethernet CRC-32 (LSB-first, reflected form).
// Purely combinational; the caller holds the running CRC register.
module crc32_d8
  import gmii_tx_pkg::*;
(
  input  logic [7:0]  data,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_R = rev32(CRC_POLY);

  // Shift eight data bits through the reflected LFSR.
  always_comb begin
    crc_out = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ POLY_R)
                           : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload, optional pad, FCS, IFG.
// Define GMII_TX_PAD_EN to pad short frames up to MIN_FRAME bytes.
module gmii_tx_framer
  import gmii_tx_pkg::*;
#(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60
) (
  input  logic       gmii_tx_clk,
  input  logic       sys_rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       frame_done,
  output logic       frame_abort
);

`ifdef GMII_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
  localparam logic [10:0] PRE_LAST = 11'(PRE_LEN - 1);
  // The IDLE->PRE hop supplies the final idle byte of the gap.
  localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 2);

  state_t      state, state_nx;
  logic [10:0] cnt, cnt_nx, cnt_inc;
  logic [31:0] crc, crc_nx, crc_upd, fcs;
  logic [7:0]  crc_din, txd_nx;
  logic        en_nx, er_nx, done_nx, abort_nx;

  assign s_ready = (state == S_DATA);
  assign fcs     = ~crc;
  assign crc_din = (state == S_DATA) ? s_data : 8'h00;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 11'd1;

  crc32_d8 u_crc (
    .data    (crc_din),
    .crc_in  (crc),
    .crc_out (crc_upd)
  );

  // Next state and next registered GMII outputs.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    crc_nx   = crc;
    txd_nx   = 8'h00;
    en_nx    = 1'b0;
    er_nx    = 1'b0;
    done_nx  = 1'b0;
    abort_nx = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (s_valid) begin
          state_nx = S_PRE;
          cnt_nx   = '0;
          crc_nx   = CRC_INIT;
        end
      end
      S_PRE: begin
        txd_nx = PREAMBLE_BYTE;
        en_nx  = 1'b1;
        cnt_nx = cnt + 11'd1;
        if (cnt == PRE_LAST) state_nx = S_SFD;
      end
      S_SFD: begin
        txd_nx   = SFD_BYTE;
        en_nx    = 1'b1;
        cnt_nx   = '0;
        state_nx = S_DATA;
      end
      S_DATA: begin
        en_nx = 1'b1;
        if (s_valid) begin
          txd_nx = s_data;
          crc_nx = crc_upd;
          cnt_nx = cnt_inc;
          if (s_last) begin
            if (PAD_EN && (cnt_inc < MIN_CNT)) begin
              state_nx = S_PAD;
            end else begin
              state_nx = S_FCS;
              cnt_nx   = '0;
            end
          end
        end else begin
          er_nx    = 1'b1;
          abort_nx = 1'b1;
          cnt_nx   = '0;
          state_nx = S_IFG;
        end
      end
`ifdef GMII_TX_PAD_EN
      S_PAD: begin
        en_nx  = 1'b1;
        crc_nx = crc_upd;
        cnt_nx = cnt_inc;
        if (cnt_inc >= MIN_CNT) begin
          state_nx = S_FCS;
          cnt_nx   = '0;
        end
      end
`endif
      S_FCS: begin
        en_nx  = 1'b1;
        txd_nx = fcs[{cnt[1:0], 3'b000} +: 8];
        cnt_nx = cnt + 11'd1;
        if (cnt[1:0] == 2'd3) begin
          done_nx  = 1'b1;
          cnt_nx   = '0;
          state_nx = S_IFG;
        end
      end
      S_IFG: begin
        cnt_nx = cnt + 11'd1;
        if (cnt == IFG_LAST) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, counters, CRC and all GMII outputs are registered.
  always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      crc         <= CRC_INIT;
      gmii_txd    <= 8'h00;
      gmii_tx_en  <= 1'b0;
      gmii_tx_er  <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      crc         <= crc_nx;
      gmii_txd    <= txd_nx;
      gmii_tx_en  <= en_nx;
      gmii_tx_er  <= er_nx;
      frame_done  <= done_nx;
      frame_abort <= abort_nx;
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Self-checking bench for gmii_tx_framer against a frame-level model.
// Follows GMII_TX_PAD_EN the same way the design does.
module tb_gmii_tx_framer;

  localparam int IFG = 12;
  localparam int MINF = 60;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic en;
    logic er;
    logic done;
    logic ab;
    logic [7:0] d;
  } smp_t;
  typedef struct {
    int len;
    int en_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic s_ready;
  logic [7:0] gmii_txd;
  logic gmii_tx_en, gmii_tx_er;
  logic frame_done, frame_abort;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] st_d[$];
  bit st_last[$];
  bit st_gap[$];
  logic [7:0] eq[$];
  int el[$];
  bit ee[$];
  smp_t cap[$];
  bit cap_on = 1'b0;
  int got_len[$];
  int got_start[$];
  int got_gap[$];

  gmii_tx_framer #(
    .IFG_BYTES (IFG),
    .MIN_FRAME (MINF)
  ) dut (
    .gmii_tx_clk (clk),
    .sys_rst     (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .gmii_txd    (gmii_txd),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_tx_er  (gmii_tx_er),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
  );

  always #4 clk = ~clk;

  // Record the GMII side 2 ns after every rising edge.
  always begin
    @(posedge clk);
    #2;
    if (cap_on) begin
      cap.push_back('{en: gmii_tx_en, er: gmii_tx_er,
                      done: frame_done, ab: frame_abort,
                      d: gmii_txd});
    end
  end

  task automatic check(input string nm, input int act,
                       input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  // Ethernet FCS, bit-serial MSB-first register fed LSB-first bits.
  function automatic logic [31:0] ref_fcs(input bq_t q);
    logic [31:0] r;
    logic [31:0] o;
    logic fb;
    r = 32'hFFFF_FFFF;
    foreach (q[j]) begin
      for (int b = 0; b < 8; b++) begin
        fb = r[31] ^ q[j][b];
        r = {r[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
      end
    end
    r = ~r;
    for (int b = 0; b < 32; b++) o[b] = r[31-b];
    return o;
  endfunction

  task automatic begin_phase();
    eq.delete();
    el.delete();
    ee.delete();
    st_d.delete();
    st_last.delete();
    st_gap.delete();
  endtask

  task automatic add_frame(input bq_t d);
    bq_t body;
    logic [31:0] f;
    body = d;
`ifdef GMII_TX_PAD_EN
    while (body.size() < MINF) body.push_back(8'h00);
`endif
    for (int j = 0; j < 7; j++) eq.push_back(8'h55);
    eq.push_back(8'hD5);
    foreach (body[j]) eq.push_back(body[j]);
    f = ref_fcs(body);
    for (int b = 0; b < 4; b++) eq.push_back(f[8*b +: 8]);
    el.push_back(8 + body.size() + 4);
    ee.push_back(1'b0);
    foreach (d[j]) begin
      st_d.push_back(d[j]);
      st_last.push_back(j == d.size() - 1);
      st_gap.push_back(1'b0);
    end
  endtask

  // Frame whose source stalls after d: error byte, no FCS.
  task automatic add_abort(input bq_t d);
    for (int j = 0; j < 7; j++) eq.push_back(8'h55);
    eq.push_back(8'hD5);
    foreach (d[j]) eq.push_back(d[j]);
    eq.push_back(8'h00);
    el.push_back(8 + d.size() + 1);
    ee.push_back(1'b1);
    foreach (d[j]) begin
      st_d.push_back(d[j]);
      st_last.push_back(1'b0);
      st_gap.push_back(j == d.size() - 1);
    end
  endtask

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int j = 0; j < n; j++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Called on a falling edge; returns on the falling edge
  // after the final byte was taken.
  task automatic drive_stream();
    int t;
    bit rdy, acc;
    for (int j = 0; j < st_d.size(); j++) begin
      s_valid = 1'b1;
      s_data = st_d[j];
      s_last = st_last[j];
      acc = 1'b0;
      t = 0;
      while (!acc && t < 200) begin
        rdy = s_ready;
        @(posedge clk);
        acc = rdy;
        t++;
        @(negedge clk);
      end
      if (!acc) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: byte %0d waited %0d cycles, limit 200",
                 j, t);
        break;
      end
      if (st_gap[j]) begin
        s_valid = 1'b0;
        s_last = 1'b0;
        @(negedge clk);
      end
    end
    st_d.delete();
    st_last.delete();
    st_gap.delete();
  endtask

  task automatic analyze(input string tag);
    int idle, pos, mm, last, nd, na, ner, xd, xa, nseg;
    got_len.delete();
    got_start.delete();
    got_gap.delete();
    idle = 0;
    nd = 0;
    na = 0;
    ner = 0;
    for (int i = 0; i < cap.size(); i++) begin
      if (cap[i].done) nd++;
      if (cap[i].ab) na++;
      if (cap[i].er) ner++;
      if (cap[i].en) begin
        if (i == 0 || !cap[i-1].en) begin
          got_start.push_back(i);
          got_len.push_back(0);
          got_gap.push_back(idle);
        end
        got_len[got_len.size()-1] += 1;
        idle = 0;
      end else begin
        idle++;
      end
    end
    check({tag, ".segments"}, got_len.size(), el.size());
    if (got_gap.size() > 0)
      check({tag, ".lead_idle"}, got_gap[0], 1);
    nseg = (got_len.size() < el.size()) ? got_len.size() : el.size();
    pos = 0;
    for (int k = 0; k < nseg; k++) begin
      check($sformatf("%s.len%0d", tag, k), got_len[k], el[k]);
      if (k > 0)
        check($sformatf("%s.ifg%0d", tag, k), got_gap[k], IFG);
      mm = 0;
      for (int j = 0; j < el[k] && j < got_len[k]; j++)
        if (cap[got_start[k]+j].d !== eq[pos+j]) mm++;
      check($sformatf("%s.byte_mismatches%0d", tag, k), mm, 0);
      last = got_start[k] + got_len[k] - 1;
      if (ee[k]) begin
        check($sformatf("%s.abort_end%0d", tag, k),
              int'(cap[last].ab), 1);
        check($sformatf("%s.er_end%0d", tag, k),
              int'(cap[last].er), 1);
      end else begin
        check($sformatf("%s.done_end%0d", tag, k),
              int'(cap[last].done), 1);
      end
      pos += el[k];
    end
    xd = 0;
    xa = 0;
    foreach (ee[k]) if (ee[k]) xa++; else xd++;
    check({tag, ".done_pulses"}, nd, xd);
    check({tag, ".abort_pulses"}, na, xa);
    check({tag, ".er_cycles"}, ner, xa);
  endtask

  task automatic run_phase(input string tag);
    cap.delete();
    cap_on = 1'b1;
    drive_stream();
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = 8'h00;
    repeat (3 * IFG + 40) @(negedge clk);
    cap_on = 1'b0;
    analyze(tag);
  endtask

  initial begin
    vec_t vt[7];
    bq_t q;
    int b0;
`ifdef GMII_TX_PAD_EN
    vt[0] = '{1, 72};
    vt[1] = '{9, 72};
    vt[2] = '{14, 72};
    vt[3] = '{59, 72};
    vt[4] = '{60, 72};
    vt[5] = '{61, 73};
    vt[6] = '{1514, 1526};
`else
    vt[0] = '{1, 13};
    vt[1] = '{9, 21};
    vt[2] = '{14, 26};
    vt[3] = '{59, 71};
    vt[4] = '{60, 72};
    vt[5] = '{61, 73};
    vt[6] = '{1514, 1526};
`endif

    // Reset state
    #10;
    check("rst.txd", int'(gmii_txd), 0);
    check("rst.en", int'(gmii_tx_en), 0);
    check("rst.er", int'(gmii_tx_er), 0);
    check("rst.ready", int'(s_ready), 0);
    check("rst.done", int'(frame_done), 0);
    check("rst.abort", int'(frame_abort), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // "123456789" (padded to MIN_FRAME when padding is built in)
    begin_phase();
    q.delete();
    for (int j = 0; j < 9; j++) q.push_back(8'h31 + 8'(j));
    add_frame(q);
    run_phase("check9");
`ifndef GMII_TX_PAD_EN
    if (got_start.size() > 0) begin
      b0 = got_start[0];
      check("check9.en_cycles", got_len[0], 21);
      check("check9.fcs0", int'(cap[b0+17].d), 'h26);
      check("check9.fcs1", int'(cap[b0+18].d), 'h39);
      check("check9.fcs2", int'(cap[b0+19].d), 'hF4);
      check("check9.fcs3", int'(cap[b0+20].d), 'hCB);
      check("check9.done_cb", int'(cap[b0+20].done), 1);
    end
`else
    if (got_start.size() > 0) begin
      b0 = got_start[0];
      check("check9.en_cycles", got_len[0], 72);
      check("check9.pad_first", int'(cap[b0+17].d), 0);
      check("check9.pad_last", int'(cap[b0+67].d), 0);
    end
`endif

    // Table of lengths, sent back to back
    begin_phase();
    for (int v = 0; v < 7; v++) add_frame(rand_bytes(vt[v].len));
    run_phase("table");
    for (int v = 0; v < 7; v++)
      if (v < got_len.size())
        check($sformatf("table.en_cycles_len%0d", vt[v].len),
              got_len[v], vt[v].en_cyc);

    // Underrun at data byte 20, then a frame right behind it
    begin_phase();
    add_abort(rand_bytes(20));
    add_frame(rand_bytes(33));
    run_phase("underrun");

    // Random back-to-back frames
    begin_phase();
    for (int f = 0; f < 8; f++)
      add_frame(rand_bytes($urandom_range(1, 120)));
    run_phase("random");

    // Reset at data byte 30, then a fresh frame with no IFG
    begin_phase();
    for (int j = 0; j < 30; j++) begin
      st_d.push_back(8'($urandom));
      st_last.push_back(1'b0);
      st_gap.push_back(1'b0);
    end
    drive_stream();
    check("midrst.en_before", int'(gmii_tx_en), 1);
    rst = 1'b1;
    s_valid = 1'b0;
    #1;
    check("midrst.en", int'(gmii_tx_en), 0);
    check("midrst.txd", int'(gmii_txd), 0);
    check("midrst.er", int'(gmii_tx_er), 0);
    check("midrst.ready", int'(s_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    begin_phase();
    add_frame(rand_bytes(45));
    run_phase("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  // Hard stop in case something never returns.
  initial begin
    #2000000;
    $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gmii_tx_framer.md
GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

Interface
REQ-001 SHALL have parameter IFG_BYTES, default 12, giving the idle bytes (tx_en low) enforced after every frame end; legal range 12..255.
REQ-002 SHALL have parameter MIN_FRAME, default 60, giving the minimum bytes (data plus pad) before FCS.
REQ-003 SHALL have port gmii_tx_clk  in  1  125 MHz clock; the single clock, all logic rising-edge.
REQ-004 SHALL have port sys_rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_data  in  8  payload byte (destination MAC onward, no FCS).
REQ-006 SHALL have port s_valid  in  1  s_data valid.
REQ-007 SHALL have port s_last  in  1  current byte is last of frame.
REQ-008 SHALL have port s_ready  out  1  byte accepted when s_valid&s_ready.
REQ-009 SHALL have ports gmii_txd  out  8,  gmii_tx_en  out  1,  gmii_tx_er  out  1;  GMII toward PCS/PMA.
REQ-010 SHALL have port frame_done  out  1  one-cycle pulse when the last FCS byte is driven.
REQ-011 SHALL have port frame_abort  out  1  one-cycle pulse on underrun.

Function
REQ-012 SHALL implement FSM IDLE -> PRE -> SFD -> DATA -> [PAD] -> FCS -> IFG -> IDLE; all GMII outputs registered.
REQ-013 SHALL leave IDLE for PRE when s_valid=1 and IFG is complete; s_ready=0 in IDLE.
REQ-014 SHALL drive 7 cycles of 0x55 in PRE, then 1 cycle of 0xD5 in SFD, with tx_en=1 and tx_er=0.
REQ-015 SHALL assert s_ready only in DATA; each accepted byte appears on gmii_txd exactly 1 cycle later.
REQ-016 SHALL, in DATA with s_valid=0 (underrun): drive tx_en=1, tx_er=1, txd=0x00 for 1 cycle; pulse frame_abort; omit FCS; go to IFG.
REQ-017 SHALL, on an accepted byte with s_last=1, go to PAD if the byte count is below MIN_FRAME, else to FCS.
REQ-018 SHALL, in PAD, send 0x00 until the byte count equals MIN_FRAME.
REQ-019 SHALL compute the IEEE 802.3 CRC-32 over data and pad: reflected polynomial 0x04C11DB7, init 0xFFFFFFFF, final inversion.
REQ-020 SHALL send the 4 FCS bytes least-significant byte first.
REQ-021 SHALL use an 11-bit byte counter saturating at 2047 and SHALL NOT truncate long frames.
REQ-022 SHALL, in IFG, hold tx_en=0, tx_er=0, txd=0x00 for exactly IFG_BYTES cycles, counted from the first cycle after the final FCS or error byte.
REQ-023 SHALL, when s_valid=1 during IFG, not assert s_ready; the new frame starts PRE on the cycle after IFG ends.
REQ-024 SHALL, when s_last=1 arrives on the first DATA byte, send a 1-byte frame, padded per REQ-017/018.

Reset
REQ-025 SHALL, while sys_rst=1, immediately force state=IDLE, gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, s_ready=0, frame_done=0, frame_abort=0, CRC=0xFFFFFFFF, counters=0.
REQ-026 SHALL, on reset mid-frame, truncate the frame with no FCS; after release, IDLE accepts a new frame without IFG.

Configuration
REQ-027 SHALL, with macro GMII_TX_PAD_EN defined, pad frames to MIN_FRAME (REQ-017/018).
REQ-028 SHALL, without GMII_TX_PAD_EN, remove the PAD state; s_last goes directly to FCS regardless of length.

Structure
REQ-029 SHALL place state encodings, PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5, CRC_INIT and CRC_POLY in shared package gmii_tx_pkg.
REQ-030 SHALL implement the CRC byte update as combinational sub-module crc32_d8 (8-bit data in, 32-bit CRC in and out).

Verification
REQ-031 SHALL verify: with GMII_TX_PAD_EN undefined, send 9 bytes "123456789" -> tx_en high 21 cycles (7x55, D5, 9 data, FCS 26 39 F4 CB), frame_done on the CB byte.
REQ-032 SHALL verify: with GMII_TX_PAD_EN defined, send a 14-byte frame -> 46 zero pad bytes, FCS over 60 bytes matching the reference model, tx_en high 72 cycles.
REQ-033 SHALL verify: drop s_valid at data byte 20 -> that byte is driven with tx_er=1, frame_abort pulses, no FCS, 12 idle cycles follow.
REQ-034 SHALL verify: present back-to-back frames with s_valid held high -> exactly IFG_BYTES idle cycles between frames, no byte lost or duplicated.
REQ-035 SHALL verify: assert sys_rst at data byte 30 -> outputs zero in the same cycle; after release, the next frame is transmitted correctly.
REQ-036 SHALL verify: send a 1514-byte frame -> no padding, FCS correct, tx_en high 1526 cycles.
